telem_tx_sched: RTL
===================

# telem_tx_sched

Transmit-side scheduler that shares the single UART transmitter (UART_tx) between two requesters. The requesters are a one-byte acknowledge path, used by command handling to echo accepted commands, and a periodic three-byte battery telemetry frame. It sits beside the authorization block in the Segway top level, drives UART_tx's `trmt`/`tx_data`, and consumes its `tx_done`.

## Interface
Parameters:
- PERIOD, default 1_048_576, clocks between telemetry frame requests (≈21 ms at 50 MHz); legal range 8..2^24.
- HDR, default 8'hA5, telemetry frame header byte.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- pwr_up  in  1  telemetry enable, from the authorization block.
- batt  in  12  battery level, unsigned.
- ack_req  in  1  one-cycle request to send ack_byte.
- ack_byte  in  8  acknowledge byte, sampled with ack_req.
- tx_done  in  1  one-cycle pulse from UART_tx: byte fully shifted out.
- trmt  out  1  one-cycle pulse that starts a UART_tx byte.
- tx_data  out  8  byte to UART_tx, registered.
- busy  out  1  high from trmt of a transfer (ack byte or full frame) until the cycle after its final tx_done.
- tel_ovr  out  1  sticky: a period expired while a telemetry frame was still pending; cleared only by reset.

## Operation
- Period timer: width ceil(log2(PERIOD)).
  - Increments each clock while pwr_up=1.
  - At PERIOD-1 it wraps to 0 and sets tel_pend.
  - While pwr_up=0: timer held at 0 and tel_pend cleared. A frame already in progress completes all 3 bytes.
- If tel_pend is already set at expiry, tel_ovr sets and no second request is queued.
- Ack path:
  - ack_req latches ack_byte into ack_buf and sets ack_pend.
  - A new ack_req while ack_pend=1: last byte wins, ack_buf overwritten.
  - ack_req during an ack byte already in flight latches a new pending ack; the in-flight tx_data is not disturbed.
- States: IDLE, ACK_TX, FRM_TX.
  - IDLE, ack_pend=1 → ACK_TX. Set trmt=1, tx_data=ack_buf, clear ack_pend. Ack has strict priority when both requests are pending.
  - IDLE, tel_pend=1 and ack_pend=0 → FRM_TX.
    - Capture batt into a 12-bit snapshot.
    - Set byte index=0, trmt=1, tx_data=HDR, clear tel_pend.
  - ACK_TX, tx_done → IDLE.
  - FRM_TX, tx_done with index<2:
    - Increment index, trmt=1.
    - tx_data = {4'h0, snap[11:8]} for index 1; snap[7:0] for index 2.
  - FRM_TX, tx_done with index=2 → IDLE.
- A frame is atomic: ack requests arriving mid-frame wait until frame end, then win arbitration.
- tx_done in IDLE is ignored.
- tx_data holds its value from trmt until the next trmt. It is never changed mid-byte.
- No state is 2'b11. An illegal encoding returns to IDLE with trmt=0.

## Timing
- Reset values: trmt=0, tx_data=8'h00, busy=0, tel_ovr=0, state IDLE, timer=0, ack_pend=0, tel_pend=0, index=0, ack_buf=8'h00.
- trmt and tx_data are registered outputs.
- ack_req high at edge k, scheduler IDLE: ack_pend=1 after edge k; trmt=1 for exactly one cycle after edge k+1.
- Timer expiry at edge k, IDLE, no ack pending: trmt after edge k+1.
- Inter-byte latency: tx_done at edge n → trmt after edge n+1. busy stays high across the gaps.
- Final tx_done at edge n → busy=0 and state IDLE after edge n+1. A pending request issues trmt after edge n+2.
- Simultaneous events at one edge:
  - ack_req with timer expiry: both latch.
  - tx_done with ack_req: both take effect.
  - pwr_up fall with expiry: tel_pend stays cleared.
- Reset mid-transfer: everything returns to reset values immediately. No further trmt until a new request.

## Test plan
- PERIOD=16, pwr_up=1, batt=12'hB3C:
  - bytes A5, 0B, 3C, each with a single trmt.
  - first trmt one cycle after the 16th counted clock.
  - busy drops one cycle after the third tx_done.
- ack_req with ack_byte=8'h67 during frame byte 1: frame finishes A5,0B,3C, then byte 67 is sent. Two ack_reqs (8'h67 then 8'h73) before frame end: only 73 is sent.
- Ack and timer expiry on the same edge, batt=12'h000: order is ack byte, then A5, 00, 00.
- UART model holds tx_done off for 3×PERIOD: tel_ovr=1, exactly one extra frame sent afterwards, no duplicate.
- pwr_up drops during byte 0 of a frame: frame completes all 3 bytes, no further trmt, timer reads 0.
- rst_n asserted mid-byte 1: trmt=0, tx_data=00, busy=0, tel_ovr=0 asynchronously. After release with pwr_up=1, first trmt after PERIOD+1 clocks.

Source files
------------

// File: rtl/telem_tx_sched.sv
// telem_tx_sched
//   Shares the single UART transmitter between a one-byte acknowledge path
//   and a periodic three-byte battery telemetry frame (HDR, batt[11:8], batt[7:0]).
//   Ack requests have strict priority at arbitration time, but a telemetry
//   frame, once started, is sent as one uninterrupted transfer.
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   pwr_up   in   telemetry enable; low parks the period timer at zero
//   batt     in   12-bit battery level, snapshotted at frame start
//   ack_req  in   one-cycle request to send ack_byte
//   ack_byte in   acknowledge byte, sampled with ack_req
//   tx_done  in   one-cycle pulse from UART_tx when a byte has been shifted out
//   trmt     out  one-cycle pulse starting a UART_tx byte (registered)
//   tx_data  out  byte for UART_tx, held from trmt until the next trmt (registered)
//   busy     out  high from the first trmt of a transfer until the cycle after its last tx_done
//   tel_ovr  out  sticky: a period expired while a frame request was still waiting
module telem_tx_sched #(
  parameter int unsigned PERIOD = 1_048_576,
  parameter logic [7:0]  HDR    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwr_up,
  input  logic [11:0] batt,
  input  logic        ack_req,
  input  logic [7:0]  ack_byte,
  input  logic        tx_done,
  output logic        trmt,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        tel_ovr
);

  localparam int unsigned   TW    = $clog2(PERIOD);
  localparam logic [TW-1:0] TZERO = {TW{1'b0}};
  localparam logic [TW-1:0] TONE  = TW'(1);
  localparam logic [TW-1:0] TMAX  = TW'(PERIOD - 1);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] ACK_TX = 2'b01;
  localparam logic [1:0] FRM_TX = 2'b10;

  logic [TW-1:0] timer_r;
  logic          tel_pend_r;
  logic          ack_pend_r;
  logic [7:0]    ack_buf_r;
  logic          tx_done_r;
  logic [11:0]   snap_r;
  logic [1:0]    state_r;
  logic [1:0]    idx_r;

  logic          expire_s;
  logic          take_ack_s;
  logic          take_tel_s;
  logic [1:0]    state_nxt_s;
  logic [1:0]    idx_nxt_s;
  logic          trmt_nxt_s;
  logic [7:0]    data_nxt_s;
  logic          busy_nxt_s;

  assign expire_s = pwr_up && (timer_r == TMAX);

  // Period timer: counts while powered, wraps at PERIOD-1, parked at zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_r <= TZERO;
    end else if (!pwr_up || expire_s) begin
      timer_r <= TZERO;
    end else begin
      timer_r <= timer_r + TONE;
    end
  end

  // Telemetry request and overrun flag. An expiry that finds a request still
  // waiting only flags the overrun; it never queues a second frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tel_pend_r <= 1'b0;
      tel_ovr    <= 1'b0;
    end else begin
      if (expire_s && tel_pend_r) begin
        tel_ovr <= 1'b1;
      end
      if (!pwr_up) begin
        tel_pend_r <= 1'b0;
      end else if (expire_s && !tel_pend_r) begin
        tel_pend_r <= 1'b1;
      end else if (take_tel_s) begin
        tel_pend_r <= 1'b0;
      end
    end
  end

  // Ack request latch: last byte wins; a new request beats the clear on the
  // same edge so it is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_pend_r <= 1'b0;
      ack_buf_r  <= 8'h00;
    end else if (ack_req) begin
      ack_pend_r <= 1'b1;
      ack_buf_r  <= ack_byte;
    end else if (take_ack_s) begin
      ack_pend_r <= 1'b0;
    end
  end

  // tx_done is registered once; the scheduler acts on the delayed copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_done_r <= 1'b0;
    end else begin
      tx_done_r <= tx_done;
    end
  end

  // Scheduler next-state: arbitration in IDLE, byte sequencing in FRM_TX.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    trmt_nxt_s  = 1'b0;
    data_nxt_s  = tx_data;
    busy_nxt_s  = busy;
    take_ack_s  = 1'b0;
    take_tel_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (ack_pend_r) begin
          state_nxt_s = ACK_TX;
          trmt_nxt_s  = 1'b1;
          data_nxt_s  = ack_buf_r;
          busy_nxt_s  = 1'b1;
          take_ack_s  = 1'b1;
        end else if (tel_pend_r) begin
          state_nxt_s = FRM_TX;
          idx_nxt_s   = 2'd0;
          trmt_nxt_s  = 1'b1;
          data_nxt_s  = HDR;
          busy_nxt_s  = 1'b1;
          take_tel_s  = 1'b1;
        end else begin
          busy_nxt_s  = 1'b0;
        end
      end
      ACK_TX: begin
        if (tx_done_r) begin
          state_nxt_s = IDLE;
          busy_nxt_s  = 1'b0;
        end else begin
          busy_nxt_s  = 1'b1;
        end
      end
      FRM_TX: begin
        if (!tx_done_r) begin
          busy_nxt_s  = 1'b1;
        end else if (idx_r >= 2'd2) begin
          state_nxt_s = IDLE;
          busy_nxt_s  = 1'b0;
        end else if (idx_r == 2'd0) begin
          idx_nxt_s   = 2'd1;
          trmt_nxt_s  = 1'b1;
          data_nxt_s  = {4'h0, snap_r[11:8]};
        end else begin
          idx_nxt_s   = 2'd2;
          trmt_nxt_s  = 1'b1;
          data_nxt_s  = snap_r[7:0];
        end
      end
      default: begin
        state_nxt_s = IDLE;
        idx_nxt_s   = 2'd0;
        trmt_nxt_s  = 1'b0;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // Scheduler registers and registered UART-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= 2'd0;
      trmt    <= 1'b0;
      tx_data <= 8'h00;
      busy    <= 1'b0;
      snap_r  <= 12'h000;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      trmt    <= trmt_nxt_s;
      tx_data <= data_nxt_s;
      busy    <= busy_nxt_s;
      if (take_tel_s) begin
        snap_r <= batt;
      end
    end
  end

endmodule
